// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the architectural HI/LO pair.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (op_i[2] = 1).
//
// state | meaning
// ------+---------------------------------------------------------------
// Idle  | waiting for start_i; MTHI/MTLO writes are accepted here
// Calc  | WIDTH iteration steps on the 2*WIDTH work register
// Fix   | sign correction / accumulate; HI/LO written at the exit edge
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] hilo_wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {Idle, Calc, Fix} stateT;

    stateT             stateQ, stateD;
    logic [CNT_W-1:0]  cntQ;
    logic [W2-1:0]     workQ;
    logic [WIDTH-1:0]  opBQ;
    logic              signAQ, signBQ, isDivQ, divZeroQ;
    logic [WIDTH-1:0]  hiQ, loQ;
    logic              doneQ, divZeroOutQ;
`ifdef MDU_MADD_EN
    logic              isAccQ, isSubQ;
`endif

    logic              opLegal, startOk, lastStep;
    logic              opSigned, negA, negB, opIsDiv;
    logic [WIDTH-1:0]  magA, magB;
    logic [WIDTH:0]    mulSum;
    logic [W2-1:0]     mulNext, divNext, stepNext;
    logic              divGe;
    logic [WIDTH-1:0]  divDiff;
    logic              resNeg;
    logic [W2-1:0]     prodRes, resHiLo;
    logic [WIDTH-1:0]  quot, rem;

`ifdef MDU_MADD_EN
    assign opLegal = 1'b1;
`else
    assign opLegal = ~op_i[2];
`endif
    assign startOk  = start_i & ~flush_i & opLegal;
    assign lastStep = (cntQ == CNT_W'(WIDTH - 1));

    // Operand conditioning at acceptance: signed ops work on magnitudes.
    always_comb begin
        opSigned = ~op_i[0];
        opIsDiv  = ~op_i[2] & op_i[1];
        negA     = opSigned & srca_i[WIDTH-1];
        negB     = opSigned & srcb_i[WIDTH-1];
        magA     = negA ? -srca_i : srca_i;
        magB     = negB ? -srcb_i : srcb_i;
    end

    // One iteration step; the work register holds {upper, lower} for both algorithms.
    always_comb begin
        mulSum   = {1'b0, workQ[W2-1:WIDTH]} + (workQ[0] ? {1'b0, opBQ} : '0);
        mulNext  = {mulSum, workQ[WIDTH-1:1]};
        divGe    = workQ[W2-1:WIDTH-1] >= {1'b0, opBQ};
        divDiff  = workQ[W2-2:WIDTH-1] - opBQ;
        divNext  = divGe ? {divDiff, workQ[WIDTH-2:0], 1'b1}
                         : {workQ[W2-2:0], 1'b0};
        stepNext = isDivQ ? divNext : mulNext;
    end

    // Final sign correction, divide-by-zero override and optional accumulate.
    always_comb begin
        resNeg  = signAQ ^ signBQ;
        prodRes = resNeg ? -workQ : workQ;
        quot    = resNeg ? -workQ[WIDTH-1:0] : workQ[WIDTH-1:0];
        if (divZeroQ) quot = '1;
        rem     = signAQ ? -workQ[W2-1:WIDTH] : workQ[W2-1:WIDTH];
`ifdef MDU_MADD_EN
        if (isDivQ)
            resHiLo = {rem, quot};
        else if (isAccQ)
            resHiLo = isSubQ ? ({hiQ, loQ} - prodRes) : ({hiQ, loQ} + prodRes);
        else
            resHiLo = prodRes;
`else
        resHiLo = isDivQ ? {rem, quot} : prodRes;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) stateQ <= Idle;
        else       stateQ <= stateD;
    end

    // Next-state logic; flush beats completion.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            Idle:    if (startOk) stateD = Calc;
            Calc:    if (flush_i) stateD = Idle;
                     else if (lastStep) stateD = Fix;
            Fix:     stateD = Idle;
            default: stateD = Idle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o = (stateQ == Calc) || (stateQ == Fix);
    end

    // Datapath, counter and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            cntQ        <= '0;
            workQ       <= '0;
            opBQ        <= '0;
            signAQ      <= 1'b0;
            signBQ      <= 1'b0;
            isDivQ      <= 1'b0;
            divZeroQ    <= 1'b0;
            hiQ         <= '0;
            loQ         <= '0;
            doneQ       <= 1'b0;
            divZeroOutQ <= 1'b0;
`ifdef MDU_MADD_EN
            isAccQ      <= 1'b0;
            isSubQ      <= 1'b0;
`endif
        end else begin
            doneQ       <= 1'b0;
            divZeroOutQ <= 1'b0;
            case (stateQ)
                Idle: begin
                    if (hi_we_i) hiQ <= hilo_wdata_i;
                    if (lo_we_i) loQ <= hilo_wdata_i;
                    if (startOk) begin
                        cntQ     <= '0;
                        workQ    <= {{WIDTH{1'b0}}, magA};
                        opBQ     <= magB;
                        signAQ   <= negA;
                        signBQ   <= negB;
                        isDivQ   <= opIsDiv;
                        divZeroQ <= opIsDiv && (srcb_i == '0);
`ifdef MDU_MADD_EN
                        isAccQ   <= op_i[2];
                        isSubQ   <= op_i[2] & op_i[1];
`endif
                    end
                end
                Calc: begin
                    if (!flush_i) begin
                        workQ <= stepNext;
                        cntQ  <= cntQ + 1'b1;
                    end
                end
                Fix: begin
                    if (!flush_i) begin
                        {hiQ, loQ}  <= resHiLo;
                        doneQ       <= 1'b1;
                        divZeroOutQ <= divZeroQ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o    = doneQ;
    assign divzero_o = divZeroOutQ;
    assign hi_o      = hiQ;
    assign lo_o      = loQ;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo at WIDTH=32.
module tb_mdu_hilo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] srca_i = '0;
    logic [31:0] srcb_i = '0;
    logic        flush_i = 1'b0;
    logic        hi_we_i = 1'b0;
    logic        lo_we_i = 1'b0;
    logic [31:0] hilo_wdata_i = '0;
    logic        busy_o, done_o, divzero_o;
    logic [31:0] hi_o, lo_o;

    int nAssert = 0;
    int nFail = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .srca_i(srca_i), .srcb_i(srcb_i), .flush_i(flush_i),
        .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .hilo_wdata_i(hilo_wdata_i),
        .busy_o(busy_o), .done_o(done_o), .divzero_o(divzero_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Starts an op (inputs change #1 after an edge) and follows it up to a cycle bound.
    // cycles = edges after the start edge until done_o is seen (0 = never seen).
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flushAt, input int disturbAt,
                         output int cycles, output int busyCnt, output logic dz,
                         output logic [31:0] hiAfterStart);
        start_i = 1'b1; op_i = op; srca_i = a; srcb_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        hiAfterStart = hi_o;
        cycles = 0; busyCnt = 0; dz = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (busy_o) busyCnt++;
            if (k == flushAt) flush_i = 1'b1;
            if (k == disturbAt) begin
                start_i = 1'b1; op_i = 3'b011; srca_i = 32'd9; srcb_i = 32'd2;
                lo_we_i = 1'b1; hilo_wdata_i = 32'hDEAD0000;
            end
            @(posedge clk); #1;
            flush_i = 1'b0; start_i = 1'b0; lo_we_i = 1'b0;
            if (done_o) begin
                cycles = k;
                dz = divzero_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        nAssert++; if (busy_o !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        nAssert++; if (done_o !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b want 0", done_o); end
        nAssert++; if (divzero_o !== 1'b0) begin nFail++; $display("FAIL reset_divzero: got %b want 0", divzero_o); end
        nAssert++; if (hi_o !== 32'h0) begin nFail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
        nAssert++; if (lo_o !== 32'h0) begin nFail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
    endtask

    task automatic test_multu_latency();
        int cyc, bc; logic dz; logic [31:0] h0;
        runOp(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (cyc != 33) begin nFail++; $display("FAIL multu_latency: got %0d want 33", cyc); end
        nAssert++; if (bc != 33) begin nFail++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        nAssert++; if (busy_o !== 1'b0) begin nFail++; $display("FAIL multu_busy_in_done: got %b want 0", busy_o); end
        nAssert++; if (hi_o !== 32'hFFFFFFFE) begin nFail++; $display("FAIL multu_hi: got %h want fffffffe", hi_o); end
        nAssert++; if (lo_o !== 32'h00000001) begin nFail++; $display("FAIL multu_lo: got %h want 00000001", lo_o); end
        nAssert++; if (dz !== 1'b0) begin nFail++; $display("FAIL multu_divzero: got %b want 0", dz); end
        @(posedge clk); #1;
        nAssert++; if (done_o !== 1'b0) begin nFail++; $display("FAIL multu_done_pulse: got %b want 0", done_o); end
    endtask

    task automatic test_arith();
        logic [2:0]  vOp [11] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b011, 3'b011, 3'b010,
                                  3'b010, 3'b010, 3'b011};
        logic [31:0] vA  [11] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000007,
                                  32'h00000007, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h80000005,
                                  32'h00000000};
        logic [31:0] vB  [11] = '{32'h00000007, 32'h80000000, 32'h00000001, 32'h00000002, 32'hFFFFFFFE,
                                  32'h00000002, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000,
                                  32'h00000000};
        logic [31:0] eHi [11] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                                  32'h00000001, 32'h00000000, 32'h00000000, 32'h12345678, 32'h80000005,
                                  32'h00000000};
        logic [31:0] eLo [11] = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                  32'h00000003, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF};
        logic        eDz [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int cyc, bc; logic dz; logic [31:0] h0;
        for (int i = 0; i < 11; i++) begin
            runOp(vOp[i], vA[i], vB[i], 0, 0, cyc, bc, dz, h0);
            nAssert++; if (cyc != 33) begin nFail++; $display("FAIL arith%0d_latency: got %0d want 33", i, cyc); end
            nAssert++; if (hi_o !== eHi[i]) begin nFail++; $display("FAIL arith%0d_hi: got %h want %h", i, hi_o, eHi[i]); end
            nAssert++; if (lo_o !== eLo[i]) begin nFail++; $display("FAIL arith%0d_lo: got %h want %h", i, lo_o, eLo[i]); end
            nAssert++; if (dz !== eDz[i]) begin nFail++; $display("FAIL arith%0d_divzero: got %b want %b", i, dz, eDz[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        int cyc, bc; logic dz; logic [31:0] h0;
        hi_we_i = 1'b1; lo_we_i = 1'b1; hilo_wdata_i = 32'hAAAA5555;
        @(posedge clk); #1;
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        runOp(3'b001, 32'd3, 32'd5, 10, 0, cyc, bc, dz, h0);
        nAssert++; if (cyc != 0) begin nFail++; $display("FAIL flush_calc_done: got done at %0d want none", cyc); end
        nAssert++; if (bc != 10) begin nFail++; $display("FAIL flush_calc_busy: got %0d want 10", bc); end
        nAssert++; if (hi_o !== 32'hAAAA5555) begin nFail++; $display("FAIL flush_calc_hi: got %h want aaaa5555", hi_o); end
        nAssert++; if (lo_o !== 32'hAAAA5555) begin nFail++; $display("FAIL flush_calc_lo: got %h want aaaa5555", lo_o); end
        runOp(3'b001, 32'd3, 32'd5, 33, 0, cyc, bc, dz, h0);
        nAssert++; if (cyc != 0) begin nFail++; $display("FAIL flush_fix_done: got done at %0d want none", cyc); end
        nAssert++; if (bc != 33) begin nFail++; $display("FAIL flush_fix_busy: got %0d want 33", bc); end
        nAssert++; if (lo_o !== 32'hAAAA5555) begin nFail++; $display("FAIL flush_fix_lo: got %h want aaaa5555", lo_o); end
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'b001; srca_i = 32'd2; srcb_i = 32'd2;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        nAssert++; if (busy_o !== 1'b0) begin nFail++; $display("FAIL flush_with_start_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_busy_ignore();
        int cyc, bc; logic dz; logic [31:0] h0;
        runOp(3'b001, 32'd3, 32'd5, 0, 5, cyc, bc, dz, h0);
        nAssert++; if (cyc != 33) begin nFail++; $display("FAIL busy_ignore_latency: got %0d want 33", cyc); end
        nAssert++; if (hi_o !== 32'h0) begin nFail++; $display("FAIL busy_ignore_hi: got %h want 0", hi_o); end
        nAssert++; if (lo_o !== 32'd15) begin nFail++; $display("FAIL busy_ignore_lo: got %h want f", lo_o); end
        @(posedge clk); #1;
        nAssert++; if (busy_o !== 1'b0) begin nFail++; $display("FAIL busy_ignore_queued: got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; logic dz; logic [31:0] h0;
        runOp(3'b011, 32'd100, 32'd7, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin nFail++; $display("FAIL b2b_first: got hi %h lo %h want 2 e", hi_o, lo_o); end
        runOp(3'b000, 32'hFFFFFFFE, 32'd3, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (cyc != 33) begin nFail++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
        nAssert++; if (hi_o !== 32'hFFFFFFFF) begin nFail++; $display("FAIL b2b_hi: got %h want ffffffff", hi_o); end
        nAssert++; if (lo_o !== 32'hFFFFFFFA) begin nFail++; $display("FAIL b2b_lo: got %h want fffffffa", lo_o); end
    endtask

    task automatic test_mthi_with_start();
        int cyc, bc; logic dz; logic [31:0] h0;
        @(posedge clk); #1;
        hi_we_i = 1'b1; hilo_wdata_i = 32'h12345678;
        runOp(3'b001, 32'd2, 32'd3, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (h0 !== 32'h12345678) begin nFail++; $display("FAIL mthi_start_lands: got %h want 12345678", h0); end
        nAssert++; if (hi_o !== 32'h0) begin nFail++; $display("FAIL mthi_start_hi: got %h want 0", hi_o); end
        nAssert++; if (lo_o !== 32'd6) begin nFail++; $display("FAIL mthi_start_lo: got %h want 6", lo_o); end
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1; op_i = 3'b001; srca_i = 32'hFFFF; srcb_i = 32'hFFFF;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nAssert++; if (busy_o !== 1'b0) begin nFail++; $display("FAIL reset_mid_busy: got %b want 0", busy_o); end
        nAssert++; if (hi_o !== 32'h0) begin nFail++; $display("FAIL reset_mid_hi: got %h want 0", hi_o); end
        nAssert++; if (lo_o !== 32'h0) begin nFail++; $display("FAIL reset_mid_lo: got %h want 0", lo_o); end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int cyc, bc; logic dz; logic [31:0] h0;
        hi_we_i = 1'b1; hilo_wdata_i = 32'h0;
        @(posedge clk); #1;
        hi_we_i = 1'b0; lo_we_i = 1'b1; hilo_wdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        lo_we_i = 1'b0;
        runOp(3'b101, 32'd1, 32'd1, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (cyc != 33) begin nFail++; $display("FAIL maddu_latency: got %0d want 33", cyc); end
        nAssert++; if (hi_o !== 32'h1 || lo_o !== 32'h0) begin nFail++; $display("FAIL maddu_result: got hi %h lo %h want 1 0", hi_o, lo_o); end
        runOp(3'b111, 32'd1, 32'd1, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (hi_o !== 32'h0 || lo_o !== 32'hFFFFFFFF) begin nFail++; $display("FAIL msubu_result: got hi %h lo %h want 0 ffffffff", hi_o, lo_o); end
        runOp(3'b110, 32'hFFFFFFFF, 32'd2, 0, 0, cyc, bc, dz, h0);
        nAssert++; if (hi_o !== 32'h1 || lo_o !== 32'h00000001) begin nFail++; $display("FAIL msub_result: got hi %h lo %h want 1 1", hi_o, lo_o); end
    endtask
`else
    task automatic test_illegal_op();
        logic sawBusy, sawDone;
        sawBusy = 1'b0; sawDone = 1'b0;
        start_i = 1'b1; op_i = 3'b100; srca_i = 32'd5; srcb_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy_o) sawBusy = 1'b1;
            if (done_o) sawDone = 1'b1;
            @(posedge clk); #1;
        end
        nAssert++; if (sawBusy !== 1'b0) begin nFail++; $display("FAIL illegal_op_busy: got %b want 0", sawBusy); end
        nAssert++; if (sawDone !== 1'b0) begin nFail++; $display("FAIL illegal_op_done: got %b want 0", sawDone); end
        nAssert++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin nFail++; $display("FAIL illegal_op_hilo: got hi %h lo %h want 0 0", hi_o, lo_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_multu_latency();
        test_arith();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_mthi_with_start();
        test_reset_mid();
`ifdef MDU_MADD_EN
        test_madd();
`else
        test_illegal_op();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
